mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-port unified instruction/data memory between the fetch stage and the memory stage of the pipelined RV32I core. It grants one requester at a time and holds the memory port stable for a fixed-latency access. It returns registered read data with a one-cycle ready pulse and produces stall requests that the hazard unit ORs into its existing stall and flush logic.

## Interface
- `ADDR_WIDTH`, 32, memory address width
- `DATA_WIDTH`, 32, memory data width
- `LATENCY`, 2, cycles the memory port must be held per access (≥1)

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `IReqF`  in  1  fetch wants the instruction at `IAddrF`
- `IAddrF`  in  ADDR_WIDTH  fetch address (PCF)
- `IAbortF`  in  1  fetch redirected (FlushD from hazard); discard the in-flight instruction
- `InstrF`  out  DATA_WIDTH  registered instruction
- `IReadyF`  out  1  `InstrF` valid, one-cycle pulse
- `DReqM`  in  1  memory stage wants a load or store
- `DWEM`  in  1  1 = store
- `DAddrM`  in  ADDR_WIDTH  data address (ALUResultM)
- `DWDataM`  in  DATA_WIDTH  store data
- `DRDataM`  out  DATA_WIDTH  registered load data
- `DReadyM`  out  1  load/store complete, one-cycle pulse
- `MemEn`  out  1  memory port active
- `MemWE`  out  1  memory write enable
- `MemAddr`  out  ADDR_WIDTH  memory address
- `MemWData`  out  DATA_WIDTH  memory write data
- `MemRData`  in  DATA_WIDTH  memory read data, valid in the last cycle of an access
- `StallFetch`  out  1  `IReqF & ~IReadyF`, combinational
- `StallMem`  out  1  `DReqM & ~DReadyM`, combinational

## Operation
- FSM states: IDLE, IACC, DACC, RESP. Down-counter `cnt` has width `$clog2(LATENCY+1)`.
- **IDLE:**
  - If `DReqM` is high, go to DACC. Data wins over fetch: the memory-stage instruction is older.
  - Else if `IReqF` is high, go to IACC.
  - On either transition, latch address, WE and write data into port registers and load `cnt = LATENCY-1`.
- **IACC/DACC:**
  - `MemEn` = 1.
  - `MemAddr`, `MemWE` and `MemWData` are driven from the latched registers and stay stable for every cycle of the access.
  - `MemWE` = 0 in IACC.
  - Decrement `cnt`. When `cnt == 0`, capture `MemRData` into `InstrF` (IACC) or `DRDataM` (DACC, loads only) and go to RESP.
- **RESP:**
  - Pulse `IReadyF` or `DReadyM` for the granted source; `MemEn` = 0.
  - Requests are ignored this cycle because the requesting stage is still presenting the same request. Always return to IDLE.
- **Stores:** `DRDataM` keeps its previous value; `DReadyM` still pulses in RESP.
- **Abort:**
  - `IAbortF` high in any cycle of IACC or RESP-for-fetch sets a sticky kill flag.
  - The memory access still runs to completion because the port is not interruptible.
  - `IReadyF` is suppressed and `InstrF` is not updated.
  - The flag clears on entering IDLE.
  - `IAbortF` has no effect on data accesses or in IDLE.
- **Starvation:** fetch cannot starve. A data request completes and the pipeline advances before the next memory-stage request.
- **Ports:** the requesting stages hold request inputs stable while stalled. The arbiter does not re-sample them mid-access.

## Timing
- A request sampled high in IDLE in cycle 0 produces:
  - `MemEn` high in cycles 1..LATENCY
  - the ready pulse in cycle LATENCY+1
  - IDLE again in cycle LATENCY+2
- Fetch-to-fetch throughput is one instruction per LATENCY+2 cycles.
- Both requests in cycle 0 (LATENCY=2):
  - data port active cycles 1–2, `DReadyM` in cycle 3
  - fetch granted in cycle 4, `MemEn` cycles 5–6, `IReadyF` in cycle 7
- `StallFetch` and `StallMem` are combinational from the request inputs and the ready outputs, so they drop in the same cycle the ready pulses.
- **Reset:**
  - Applies at any point, including mid-access, at the next rising edge with `rst_n` = 0.
  - State → IDLE, `cnt` → 0, kill flag → 0.
  - `MemEn`, `MemWE`, `MemAddr`, `MemWData`, `InstrF`, `DRDataM`, `IReadyF`, `DReadyM` → 0.
  - No ready pulse is issued for the interrupted access.
- LATENCY=1: a single access cycle, ready in cycle 2.

## Test plan
- **Single fetch, LATENCY=2:** `IReqF`=1, `IAddrF`=0x0000_0010, memory returns 0x0050_0093 → `MemEn` cycles 1–2 with address 0x10, `IReadyF` and `InstrF`=0x0050_0093 in cycle 3, `StallFetch` high cycles 0–2.
- **Contention:** `IReqF`=`DReqM`=1 in the same cycle, load from 0x100 returning 0xDEAD_BEEF → `DReadyM` with 0xDEAD_BEEF in cycle 3, fetch access cycles 5–6, `IReadyF` in cycle 7.
- **Store:** `DReqM`=`DWEM`=1, `DAddrM`=0x200, `DWDataM`=0x1234_5678 → `MemWE`=1 with stable address/data cycles 1–2, `DReadyM` in cycle 3, `DRDataM` unchanged.
- **Abort:** fetch started, `IAbortF` pulsed in cycle 1 → `MemEn` still high cycles 1–2, no `IReadyF` in cycle 3, `InstrF` unchanged, a new fetch accepted in cycle 4.
- **Reset mid-access:** `rst_n`=0 in cycle 1 of a load → all outputs 0 next cycle, no `DReadyM`; after release with `DReqM` still high, the load restarts from IDLE.
- **LATENCY=1 build:** back-to-back fetches → `IReadyF` every 3 cycles, `MemEn` one cycle each.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port unified instruction/data memory between
// the fetch stage and the memory stage.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | port idle; data request wins over fetch, latch port regs
//  IACC  | fetch access in progress, port held stable for LATENCY cycles
//  DACC  | load/store access in progress, port held stable
//  RESP  | one-cycle ready pulse for the granted source, then IDLE
//
// Fetch cannot starve: the data side always passes through RESP and IDLE,
// and the memory stage drops its request once the pipeline advances, so a
// waiting fetch is granted in the IDLE cycle that follows.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  IReqF,
   input  logic [ADDR_WIDTH-1:0] IAddrF,
   input  logic                  IAbortF,
   output logic [DATA_WIDTH-1:0] InstrF,
   output logic                  IReadyF,
   input  logic                  DReqM,
   input  logic                  DWEM,
   input  logic [ADDR_WIDTH-1:0] DAddrM,
   input  logic [DATA_WIDTH-1:0] DWDataM,
   output logic [DATA_WIDTH-1:0] DRDataM,
   output logic                  DReadyM,
   output logic                  MemEn,
   output logic                  MemWE,
   output logic [ADDR_WIDTH-1:0] MemAddr,
   output logic [DATA_WIDTH-1:0] MemWData,
   input  logic [DATA_WIDTH-1:0] MemRData,
   output logic                  StallFetch,
   output logic                  StallMem
);

   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_IACC = 2'd1,
      S_DACC = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t                state_q,  state_d;
   logic [CW-1:0]         cnt_q,    cnt_d;
   logic                  src_d_q,  src_d_d;   // granted source: 1 = data
   logic                  kill_q,   kill_d;
   logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
   logic                  we_q,     we_d;
   logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
   logic [DATA_WIDTH-1:0] instr_q,  instr_d;
   logic [DATA_WIDTH-1:0] drdata_q, drdata_d;

   logic fetch_owned;
   logic kill_now;

   // An abort raised in the current cycle must already block the capture
   // and the ready pulse, not only from the next cycle on.
   assign fetch_owned = (state_q == S_IACC) || ((state_q == S_RESP) && !src_d_q);
   assign kill_now    = kill_q || (IAbortF && fetch_owned);

   // State and port/datapath registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         src_d_q  <= 1'b0;
         kill_q   <= 1'b0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         instr_q  <= '0;
         drdata_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         src_d_q  <= src_d_d;
         kill_q   <= kill_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         instr_q  <= instr_d;
         drdata_q <= drdata_d;
      end
   end

   // Next-state logic: grant, access countdown, read-data capture, abort.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      src_d_d  = src_d_q;
      kill_d   = kill_q;
      addr_d   = addr_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      instr_d  = instr_q;
      drdata_d = drdata_q;

      unique case (state_q)
         S_IDLE: begin
            kill_d = 1'b0;
            if (DReqM) begin
               state_d = S_DACC;
               src_d_d = 1'b1;
               addr_d  = DAddrM;
               we_d    = DWEM;
               wdata_d = DWDataM;
               cnt_d   = CNT_LOAD;
            end else if (IReqF) begin
               state_d = S_IACC;
               src_d_d = 1'b0;
               addr_d  = IAddrF;
               we_d    = 1'b0;
               wdata_d = '0;
               cnt_d   = CNT_LOAD;
            end
         end

         S_IACC: begin
            kill_d = kill_now;
            if (cnt_q == '0) begin
               if (!kill_now) begin
                  instr_d = MemRData;
               end
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         S_DACC: begin
            if (cnt_q == '0) begin
               if (!we_q) begin
                  drdata_d = MemRData;
               end
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         S_RESP: begin
            kill_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from the state and the latched port registers.
   always_comb begin
      MemEn    = (state_q == S_IACC) || (state_q == S_DACC);
      MemWE    = (state_q == S_DACC) && we_q;
      MemAddr  = addr_q;
      MemWData = wdata_q;
      IReadyF  = (state_q == S_RESP) && !src_d_q && !kill_now;
      DReadyM  = (state_q == S_RESP) && src_d_q;
      InstrF   = instr_q;
      DRDataM  = drdata_q;
   end

   assign StallFetch = IReqF & ~IReadyF;
   assign StallMem   = DReqM & ~DReadyM;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed steps on a LATENCY=2 instance, then
// back-to-back fetches on a LATENCY=1 instance. Ready responses are matched
// against a queue of expected results pushed when each request is driven.
module tb_mem_arbiter;

   typedef struct {
      bit          is_data;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_run;
   int n_fail;
   exp_t qa[$];
   exp_t qb[$];

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      case (a)
         32'h0000_0010: return 32'h0050_0093;
         32'h0000_0100: return 32'hDEAD_BEEF;
         default:       return a ^ 32'hA5A5_0000;
      endcase
   endfunction

   // LATENCY=2 instance signals
   logic        IReqF_a, IAbortF_a, IReadyF_a, DReqM_a, DWEM_a, DReadyM_a;
   logic        MemEn_a, MemWE_a, StallFetch_a, StallMem_a;
   logic [31:0] IAddrF_a, InstrF_a, DAddrM_a, DWDataM_a, DRDataM_a;
   logic [31:0] MemAddr_a, MemWData_a, MemRData_a;

   // LATENCY=1 instance signals
   logic        IReqF_b, IAbortF_b, IReadyF_b, DReqM_b, DWEM_b, DReadyM_b;
   logic        MemEn_b, MemWE_b, StallFetch_b, StallMem_b;
   logic [31:0] IAddrF_b, InstrF_b, DAddrM_b, DWDataM_b, DRDataM_b;
   logic [31:0] MemAddr_b, MemWData_b, MemRData_b;

   assign MemRData_a = mem_model(MemAddr_a);
   assign MemRData_b = mem_model(MemAddr_b);

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(2)) u_a (
      .clk(clk), .rst_n(rst_n),
      .IReqF(IReqF_a), .IAddrF(IAddrF_a), .IAbortF(IAbortF_a),
      .InstrF(InstrF_a), .IReadyF(IReadyF_a),
      .DReqM(DReqM_a), .DWEM(DWEM_a), .DAddrM(DAddrM_a), .DWDataM(DWDataM_a),
      .DRDataM(DRDataM_a), .DReadyM(DReadyM_a),
      .MemEn(MemEn_a), .MemWE(MemWE_a), .MemAddr(MemAddr_a),
      .MemWData(MemWData_a), .MemRData(MemRData_a),
      .StallFetch(StallFetch_a), .StallMem(StallMem_a)
   );

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(1)) u_b (
      .clk(clk), .rst_n(rst_n),
      .IReqF(IReqF_b), .IAddrF(IAddrF_b), .IAbortF(IAbortF_b),
      .InstrF(InstrF_b), .IReadyF(IReadyF_b),
      .DReqM(DReqM_b), .DWEM(DWEM_b), .DAddrM(DAddrM_b), .DWDataM(DWDataM_b),
      .DRDataM(DRDataM_b), .DReadyM(DReadyM_b),
      .MemEn(MemEn_b), .MemWE(MemWE_b), .MemAddr(MemAddr_b),
      .MemWData(MemWData_b), .MemRData(MemRData_b),
      .StallFetch(StallFetch_b), .StallMem(StallMem_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Pop the scoreboard whenever an instance pulses a ready.
   task automatic mon();
      exp_t e;
      if (IReadyF_a || DReadyM_a) begin
         if (qa.size() == 0) begin
            chk("spurious_ready_a", {30'd0, IReadyF_a, DReadyM_a}, 32'd0);
         end else begin
            e = qa.pop_front();
            chk("src_a", {31'd0, DReadyM_a}, {31'd0, e.is_data});
            chk("data_a", e.is_data ? DRDataM_a : InstrF_a, e.data);
         end
      end
      if (IReadyF_b || DReadyM_b) begin
         if (qb.size() == 0) begin
            chk("spurious_ready_b", {30'd0, IReadyF_b, DReadyM_b}, 32'd0);
         end else begin
            e = qb.pop_front();
            chk("data_b", InstrF_b, e.data);
         end
      end
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic step();
      mon();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_run = 0;
      n_fail = 0;
      rst_n = 1'b0;
      IReqF_a = 0; IAbortF_a = 0; DReqM_a = 0; DWEM_a = 0;
      IAddrF_a = '0; DAddrM_a = '0; DWDataM_a = '0;
      IReqF_b = 0; IAbortF_b = 0; DReqM_b = 0; DWEM_b = 0;
      IAddrF_b = '0; DAddrM_b = '0; DWDataM_b = '0;

      // reset
      @(posedge clk); #1;
      @(posedge clk); #1;
      mid();
      chk("rst_memen",  MemEn_a, 0);
      chk("rst_memwe",  MemWE_a, 0);
      chk("rst_addr",   MemAddr_a, 0);
      chk("rst_wdata",  MemWData_a, 0);
      chk("rst_instr",  InstrF_a, 0);
      chk("rst_drdata", DRDataM_a, 0);
      chk("rst_iready", IReadyF_a, 0);
      chk("rst_dready", DReadyM_a, 0);
      step();
      rst_n = 1'b1;
      mid(); step();

      // single fetch
      IReqF_a = 1; IAddrF_a = 32'h10;
      qa.push_back('{1'b0, 32'h0050_0093});
      mid(); chk("t1_stall_c0", StallFetch_a, 1); chk("t1_memen_c0", MemEn_a, 0); step();
      for (int c = 1; c <= 2; c++) begin
         mid();
         chk("t1_memen", MemEn_a, 1);
         chk("t1_addr", MemAddr_a, 32'h10);
         chk("t1_we", MemWE_a, 0);
         chk("t1_stall", StallFetch_a, 1);
         step();
      end
      mid();
      chk("t1_iready_c3", IReadyF_a, 1);
      chk("t1_instr_c3", InstrF_a, 32'h0050_0093);
      chk("t1_stall_c3", StallFetch_a, 0);
      chk("t1_memen_c3", MemEn_a, 0);
      step();
      IReqF_a = 0;
      mid(); chk("t1_memen_c4", MemEn_a, 0); step();

      // contention: data first, then fetch
      IReqF_a = 1; IAddrF_a = 32'h14;
      DReqM_a = 1; DWEM_a = 0; DAddrM_a = 32'h100;
      qa.push_back('{1'b1, 32'hDEAD_BEEF});
      qa.push_back('{1'b0, 32'hA5A5_0014});
      mid(); step();
      for (int c = 1; c <= 2; c++) begin
         mid();
         chk("t2_memen_d", MemEn_a, 1);
         chk("t2_addr_d", MemAddr_a, 32'h100);
         chk("t2_stallm", StallMem_a, 1);
         chk("t2_stallf", StallFetch_a, 1);
         step();
      end
      mid();
      chk("t2_dready_c3", DReadyM_a, 1);
      chk("t2_drdata_c3", DRDataM_a, 32'hDEAD_BEEF);
      chk("t2_stallm_c3", StallMem_a, 0);
      chk("t2_iready_c3", IReadyF_a, 0);
      step();
      DReqM_a = 0;
      mid(); chk("t2_memen_c4", MemEn_a, 0); step();
      for (int c = 5; c <= 6; c++) begin
         mid();
         chk("t2_memen_i", MemEn_a, 1);
         chk("t2_addr_i", MemAddr_a, 32'h14);
         step();
      end
      mid();
      chk("t2_iready_c7", IReadyF_a, 1);
      chk("t2_instr_c7", InstrF_a, 32'hA5A5_0014);
      step();
      IReqF_a = 0;
      mid(); step();

      // store; inputs perturbed mid-access must not reach the port
      DReqM_a = 1; DWEM_a = 1; DAddrM_a = 32'h200; DWDataM_a = 32'h1234_5678;
      qa.push_back('{1'b1, 32'hDEAD_BEEF});
      mid(); step();
      for (int c = 1; c <= 2; c++) begin
         if (c == 2) begin
            DAddrM_a = 32'hFFF; DWDataM_a = 32'h0;
         end
         mid();
         chk("t3_memen", MemEn_a, 1);
         chk("t3_we", MemWE_a, 1);
         chk("t3_addr", MemAddr_a, 32'h200);
         chk("t3_wdata", MemWData_a, 32'h1234_5678);
         step();
      end
      mid();
      chk("t3_dready_c3", DReadyM_a, 1);
      chk("t3_drdata_c3", DRDataM_a, 32'hDEAD_BEEF);
      chk("t3_we_c3", MemWE_a, 0);
      step();
      DReqM_a = 0; DWEM_a = 0; DWDataM_a = 0; DAddrM_a = 0;
      mid(); step();

      // abort
      IReqF_a = 1; IAddrF_a = 32'h40;
      mid(); step();
      IAbortF_a = 1;
      mid(); chk("t4_memen_c1", MemEn_a, 1); chk("t4_addr_c1", MemAddr_a, 32'h40); step();
      IAbortF_a = 0; IAddrF_a = 32'h80;
      mid(); chk("t4_memen_c2", MemEn_a, 1); chk("t4_addr_c2", MemAddr_a, 32'h40); step();
      mid();
      chk("t4_iready_c3", IReadyF_a, 0);
      chk("t4_instr_c3", InstrF_a, 32'hA5A5_0014);
      chk("t4_stall_c3", StallFetch_a, 1);
      step();
      qa.push_back('{1'b0, 32'hA5A5_0080});
      mid(); chk("t4_memen_c4", MemEn_a, 0); step();
      mid(); chk("t4_memen_c5", MemEn_a, 1); chk("t4_addr_c5", MemAddr_a, 32'h80); step();
      mid(); step();
      mid();
      chk("t4_iready_c7", IReadyF_a, 1);
      chk("t4_instr_c7", InstrF_a, 32'hA5A5_0080);
      step();
      IReqF_a = 0;
      mid(); step();

      // reset in the middle of a load, then the load restarts
      DReqM_a = 1; DWEM_a = 0; DAddrM_a = 32'h300;
      qa.push_back('{1'b1, 32'hA5A5_0300});
      mid(); step();
      rst_n = 1'b0;
      mid(); chk("t5_memen_c1", MemEn_a, 1); step();
      rst_n = 1'b1;
      mid();
      chk("t5_memen_c2", MemEn_a, 0);
      chk("t5_addr_c2", MemAddr_a, 0);
      chk("t5_drdata_c2", DRDataM_a, 0);
      chk("t5_instr_c2", InstrF_a, 0);
      chk("t5_dready_c2", DReadyM_a, 0);
      chk("t5_stallm_c2", StallMem_a, 1);
      step();
      mid(); chk("t5_memen_c3", MemEn_a, 1); chk("t5_addr_c3", MemAddr_a, 32'h300); chk("t5_dready_c3", DReadyM_a, 0); step();
      mid(); chk("t5_dready_c4", DReadyM_a, 0); step();
      mid(); chk("t5_dready_c5", DReadyM_a, 1); chk("t5_drdata_c5", DRDataM_a, 32'hA5A5_0300); step();
      DReqM_a = 0;
      mid(); step();

      // LATENCY=1: back-to-back fetches, ready every third cycle
      for (int c = 0; c < 9; c++) begin
         IReqF_b = 1;
         IAddrF_b = 32'h1000 + 32'(c / 3) * 4;
         if (c % 3 == 0) qb.push_back('{1'b0, mem_model(IAddrF_b)});
         mid();
         chk("l1_memen", {31'd0, MemEn_b}, {31'd0, (c % 3 == 1)});
         chk("l1_iready", {31'd0, IReadyF_b}, {31'd0, (c % 3 == 2)});
         chk("l1_stall", {31'd0, StallFetch_b}, {31'd0, (c % 3 != 2)});
         if (c % 3 == 1) chk("l1_addr", MemAddr_b, IAddrF_b);
         step();
      end
      IReqF_b = 0;
      mid();
      chk("l1_memwe", MemWE_b, 0);
      chk("l1_wdata", MemWData_b, 0);
      chk("l1_drdata", DRDataM_b, 0);
      chk("l1_stallm", StallMem_b, 0);
      step();

      chk("qa_drained", qa.size(), 0);
      chk("qb_drained", qb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
